ecc_scrubber: RTL and testbench

- Background scrubber placed downstream of the dual-port RAM. It owns RAM port B.
- Walks an address range. At each address it reads the 12-bit Hamming(12,8) codeword and computes the syndrome.
- It writes back the corrected codeword on a single-bit error and counts correctable and uncorrectable events.
- Port A remains with the encoder/decoder datapath.

---
 rtl/ecc_pkg.sv | 34 +++
 rtl/ham_syndrome_chk.sv | 21 ++
 rtl/ecc_scrubber.sv | 112 +++++++++++
 tb/tb_ecc_scrubber.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - Hamming(12,8) constants, syndrome helper and scrubber FSM states
package ecc_pkg;

  localparam int CW_WIDTH  = 12;
  localparam int DATA_BITS = 8;

  // Hamming positions are 1-based; codeword bit i holds position i+1
  localparam int PARITY_POS [4] = '{1, 2, 4, 8};
  localparam int DATA_POS   [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef logic [3:0] syndrome_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_CHECK,
    S_WR_REQ,
    S_WR_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  // XOR of the position numbers of every set bit
  function automatic syndrome_t hamming_syndrome(input logic [CW_WIDTH-1:0] cw);
    syndrome_t s;
    s = '0;
    for (int i = 0; i < CW_WIDTH; i++) begin
      if (cw[i]) s = s ^ 4'(i + 1);
    end
    return s;
  endfunction

endpackage

// File: rtl/ham_syndrome_chk.sv
// rtl/ham_syndrome_chk.sv - combinational Hamming(12,8) syndrome and single-bit correction
module ham_syndrome_chk
  import ecc_pkg::*;
(
  input  logic [CW_WIDTH-1:0] cw,
  output syndrome_t           syndrome,
  output logic [CW_WIDTH-1:0] corrected,
  output logic                uncorrectable
);

  // syndromes 13..15 point outside the codeword and cannot be repaired
  always_comb begin
    syndrome      = hamming_syndrome(cw);
    uncorrectable = (syndrome > 4'd12);
    corrected     = cw;
    for (int i = 0; i < CW_WIDTH; i++) begin
      if (syndrome == 4'(i + 1)) corrected[i] = ~cw[i];
    end
  end

endmodule

// File: rtl/ecc_scrubber.sv
// rtl/ecc_scrubber.sv - background scrubber owning RAM port B over an address range
module ecc_scrubber
  import ecc_pkg::*;
#(
  parameter int ADDR_WIDTH    = 3,
  parameter int DATA_WIDTH    = 12,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 3,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_end_addr,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_en,
  output logic                  o_we,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [CNT_WIDTH-1:0]  o_corr_cnt,
  output logic [CNT_WIDTH-1:0]  o_uncorr_cnt,
  output logic [ADDR_WIDTH-1:0] o_err_addr
);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, end_q;
  logic [DATA_WIDTH-1:0] rdata_q, wdata_q;
  logic [7:0]            wait_cnt;
  syndrome_t             syn;
  logic [DATA_WIDTH-1:0] fixed;
  logic                  uncorr;

  ham_syndrome_chk u_chk (
    .cw            (rdata_q),
    .syndrome      (syn),
    .corrected     (fixed),
    .uncorrectable (uncorr)
  );

  // state register; reset withdraws any request strobe immediately
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // next state and port-B strobes; abort overrides every transition
  always_comb begin
    state_n = state;
    o_en    = 1'b0;
    o_we    = 1'b0;
    o_busy  = (state != S_IDLE);
    o_done  = 1'b0;
    case (state)
      S_IDLE:    if (i_start) state_n = S_RD_REQ;
      S_RD_REQ:  begin o_en = 1'b1; state_n = S_RD_WAIT; end
      S_RD_WAIT: if (wait_cnt == 8'(READ_LATENCY - 1)) state_n = S_CHECK;
      S_CHECK:   state_n = (syn != '0 && !uncorr) ? S_WR_REQ : S_NEXT;
      S_WR_REQ:  begin o_en = 1'b1; o_we = 1'b1; state_n = S_WR_WAIT; end
      S_WR_WAIT: if (wait_cnt == 8'(WRITE_LATENCY - 1)) state_n = S_NEXT;
      S_NEXT:    state_n = (ptr == end_q) ? S_DONE : S_RD_REQ;
      S_DONE:    begin o_done = 1'b1; state_n = S_IDLE; end
      default:   state_n = S_IDLE;
    endcase
    if (i_abort) state_n = S_IDLE;
  end

  // datapath: pointer, captured word, correction, error bookkeeping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr          <= '0;
      end_q        <= '0;
      rdata_q      <= '0;
      wdata_q      <= '0;
      wait_cnt     <= '0;
      o_corr_cnt   <= '0;
      o_uncorr_cnt <= '0;
      o_err_addr   <= '0;
    end else begin
      wait_cnt <= (state_n == state) ? wait_cnt + 8'd1 : 8'd0;
      if (!i_abort) begin
        case (state)
          S_IDLE: if (i_start) begin
            ptr          <= i_start_addr;
            end_q        <= i_end_addr;
            o_corr_cnt   <= '0;
            o_uncorr_cnt <= '0;
          end
          S_RD_WAIT: if (wait_cnt == 8'(READ_LATENCY - 1)) rdata_q <= i_rdata;
          S_CHECK: if (syn != '0) begin
            o_err_addr <= ptr;
            if (uncorr) begin
              if (o_uncorr_cnt != '1) o_uncorr_cnt <= o_uncorr_cnt + 1'b1;
            end else begin
              wdata_q <= fixed;
              if (o_corr_cnt != '1) o_corr_cnt <= o_corr_cnt + 1'b1;
            end
          end
          S_NEXT: if (ptr != end_q) ptr <= ptr + 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign o_addr  = ptr;
  assign o_wdata = wdata_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// tb/tb_ecc_scrubber.sv - scoreboard bench for ecc_scrubber with a latency-3 RAM model
module tb_ecc_scrubber;

  localparam int AW = 3;
  localparam int DW = 12;
  localparam int CW = 2;
  localparam logic [DW-1:0] CLEAN = 12'hA58;

  logic          clk = 1'b0;
  logic          rst_n, start, abort;
  logic [AW-1:0] start_addr, end_addr;
  logic [AW-1:0] o_addr, o_err_addr;
  logic          o_en, o_we, o_busy, o_done;
  logic [DW-1:0] o_wdata, i_rdata;
  logic [CW-1:0] o_corr_cnt, o_uncorr_cnt;

  always #5 clk = ~clk;

  ecc_scrubber #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(3),
    .WRITE_LATENCY(3), .CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_start_addr(start_addr), .i_end_addr(end_addr),
    .o_addr(o_addr), .o_en(o_en), .o_we(o_we), .o_wdata(o_wdata),
    .i_rdata(i_rdata), .o_busy(o_busy), .o_done(o_done),
    .o_corr_cnt(o_corr_cnt), .o_uncorr_cnt(o_uncorr_cnt), .o_err_addr(o_err_addr)
  );

  // RAM port B model: read data valid 3 edges after the request edge
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rd1 = '0, rd2 = '0, rd3 = '0;
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  int            cyc = 0;
  int            start_cyc = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (o_en && o_we) mem[o_addr] <= o_wdata;
    if (o_en && !o_we) rd1 <= mem[o_addr];
    rd2 <= rd1;
    rd3 <= rd2;
    cyc <= cyc + 1;
  end
  assign i_rdata = rd3;

  typedef struct {
    int kind;   // 0 read, 1 write, 2 done
    int addr;
    int data;
    int corr;
    int uncorr;
    int err;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h need 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int kind, input int addr, input int data,
                      input int corr, input int uncorr, input int err, input int lat);
    exp_t x;
    x.kind = kind; x.addr = addr; x.data = data;
    x.corr = corr; x.uncorr = uncorr; x.err = err; x.lat = lat;
    exp_q.push_back(x);
  endtask

  // monitor: every RAM request and every done pulse must match the queue head
  always @(negedge clk) begin
    if (rst_n && (o_en || o_done)) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: en=%0d we=%0d addr=%0d done=%0d, none required",
                 o_en, o_we, o_addr, o_done);
      end else begin
        e = exp_q.pop_front();
        if (o_en) begin
          check("req_kind", o_we ? 1 : 0, e.kind);
          check("req_addr", int'(o_addr), e.addr);
          if (o_we) check("req_wdata", int'(o_wdata), e.data);
        end else begin
          check("done_kind", 2, e.kind);
          check("done_corr", int'(o_corr_cnt), e.corr);
          check("done_uncorr", int'(o_uncorr_cnt), e.uncorr);
          check("done_err_addr", int'(o_err_addr), e.err);
          check("done_latency", cyc - start_cyc, e.lat);
        end
      end
    end
  end

  task automatic preload(input int a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = AW'(a); pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic run(input int s, input int en);
    start = 1'b1; start_addr = AW'(s); end_addr = AW'(en);
    @(posedge clk); #1;
    start_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (o_busy) begin
      total++; bad++;
      $display("FAIL idle_timeout: busy=%0d after %0d cycles, need 0", o_busy, n);
    end
    @(posedge clk); #1;
  endtask

  function automatic int all_outs();
    return int'({o_addr, o_en, o_we, o_wdata, o_busy, o_done,
                 o_corr_cnt, o_uncorr_cnt, o_err_addr});
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = '0; end_addr = '0;
    #12;
    check("reset_outputs", all_outs(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) preload(i, CLEAN);

    // clean word
    push(0, 1, 0, 0, 0, 0, 0);
    push(2, 0, 0, 0, 0, 0, 6);
    run(1, 1); wait_idle();
    check("clean_mem1", int'(mem[1]), 'hA58);

    // single-bit error at position 6
    preload(2, 12'hA78);
    push(0, 2, 0, 0, 0, 0, 0);
    push(1, 2, 'hA58, 0, 0, 0, 0);
    push(2, 0, 0, 1, 0, 2, 10);
    run(2, 2); wait_idle();
    check("sbe_mem2", int'(mem[2]), 'hA58);

    // uncorrectable, syndrome 13
    preload(3, 12'h259);
    push(0, 3, 0, 0, 0, 0, 0);
    push(2, 0, 0, 0, 1, 3, 6);
    run(3, 3); wait_idle();
    check("uncorr_mem3", int'(mem[3]), 'h259);

    // wrapping range 6..1; err_addr keeps the last nonzero-syndrome address
    preload(3, CLEAN);
    push(0, 6, 0, 0, 0, 0, 0);
    push(0, 7, 0, 0, 0, 0, 0);
    push(0, 0, 0, 0, 0, 0, 0);
    push(0, 1, 0, 0, 0, 0, 0);
    push(2, 0, 0, 0, 0, 3, 24);
    run(6, 1); wait_idle();

    // abort in WR_WAIT: committed write stays, no done pulse
    preload(2, 12'hA78);
    push(0, 2, 0, 0, 0, 0, 0);
    push(1, 2, 'hA58, 0, 0, 0, 0);
    run(2, 2);
    repeat (6) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", int'(o_busy), 0);
    check("abort_corr", int'(o_corr_cnt), 1);
    check("abort_mem2", int'(mem[2]), 'hA58);
    repeat (10) @(posedge clk);
    #1;

    // four corrupted words saturate the 2-bit counter at 3
    preload(0, 12'hA59);
    preload(1, 12'hA5A);
    preload(2, 12'hA5C);
    preload(3, 12'hE58);
    for (int i = 0; i < 4; i++) begin
      push(0, i, 0, 0, 0, 0, 0);
      push(1, i, 'hA58, 0, 0, 0, 0);
    end
    push(2, 0, 0, 3, 0, 3, 40);
    run(0, 3); wait_idle();
    for (int i = 0; i < 4; i++) check("sat_mem", int'(mem[i]), 'hA58);

    // asynchronous reset during the read wait
    push(0, 5, 0, 0, 0, 0, 0);
    run(5, 5);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 0);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
